// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with a single outstanding request,
//               one-entry skid buffer and IF/ID output register.
//               Misaligned PCs produce an address-error entry instead of a
//               bus request.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous active-high reset
//   inst_req        fetch request valid
//   inst_addr       fetch address (always the current PC)
//   inst_addr_ok    request accepted this cycle
//   inst_data_ok    instruction data returned this cycle
//   inst_rdata      returned instruction word
//   redirect_valid  branch/jump/exception redirect
//   redirect_pc     redirect target
//   stall           decode cannot consume id_* this cycle
//   id_valid        IF/ID register holds an instruction
//   id_pc           PC of id_instr
//   id_instr        instruction word for the decoder
//   id_adel         id entry is an address-error fault
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_adel
);

    typedef enum logic [2:0] {
        S_REQ     = 3'd0,
        S_WAIT    = 3'd1,
        S_SKID    = 3'd2,
        S_DISCARD = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_adel_q, id_adel_d;
    // The skid entry's PC is always pc_q: the PC only advances once the
    // skid word has moved into IF/ID, so only the word itself is stored.
    logic [31:0] skid_instr_q, skid_instr_d;

    logic        w_id_ready;
    logic        w_aligned;
    logic [31:0] w_pc_inc;

    assign w_id_ready = !id_valid_q || !stall;
    assign w_aligned  = (pc_q[1:0] == 2'b00);
    assign w_pc_inc   = pc_q + 32'd4;

    assign inst_addr  = pc_q;
    assign id_valid   = id_valid_q;
    assign id_pc      = id_pc_q;
    assign id_instr   = id_instr_q;
    assign id_adel    = id_adel_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        id_adel_d    = id_adel_q;
        skid_instr_d = skid_instr_q;
        inst_req     = 1'b0;

        // A consumed entry drops out unless a load below replaces it.
        if (w_id_ready) begin
            id_valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (w_aligned) begin
                    inst_req = 1'b1;
                    if (inst_addr_ok) begin
                        state_d = S_WAIT;
                    end
                end else if (w_id_ready) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = pc_q;
                    id_instr_d = 32'h0;
                    id_adel_d  = 1'b1;
                    state_d    = S_ERR;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    if (w_id_ready) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = pc_q;
                        id_instr_d = inst_rdata;
                        id_adel_d  = 1'b0;
                        pc_d       = w_pc_inc;
                        state_d    = S_REQ;
                    end else begin
                        skid_instr_d = inst_rdata;
                        state_d      = S_SKID;
                    end
                end
            end
            S_SKID: begin
                if (w_id_ready) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = pc_q;
                    id_instr_d = skid_instr_q;
                    id_adel_d  = 1'b0;
                    pc_d       = w_pc_inc;
                    state_d    = S_REQ;
                end
            end
            S_DISCARD: begin
                if (inst_data_ok) begin
                    state_d = S_REQ;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Redirect overrides everything above. If a request is still in
        // flight on the bus after this cycle, its data must be thrown away.
        if (redirect_valid) begin
            pc_d         = redirect_pc;
            id_valid_d   = 1'b0;
            skid_instr_d = 32'h0;
            case (state_q)
                S_REQ:     state_d = (inst_req && inst_addr_ok) ? S_DISCARD : S_REQ;
                S_WAIT:    state_d = inst_data_ok ? S_REQ : S_DISCARD;
                S_DISCARD: state_d = inst_data_ok ? S_REQ : S_DISCARD;
                default:   state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_pc_q      <= 32'h0;
            id_instr_q   <= 32'h0;
            id_adel_q    <= 1'b0;
            skid_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_adel_q    <= id_adel_d;
            skid_instr_q <= skid_instr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed testbench for fetch_stage. Inputs change 1 ns after
//               the rising edge; outputs are sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_adel;

    int errors = 0;
    int checks = 0;

    fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_adel        (id_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        redirect_valid = 1'b1;      // reset must win over redirect
        redirect_pc    = 32'h1234_5678;
        tick();
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
        checks++; if (inst_req !== 1'b1) begin errors++; $display("FAIL reset_inst_req: got %b expected 1", inst_req); end
        checks++; if (inst_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_inst_addr: got %h expected bfc00000", inst_addr); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_id_instr: got %h expected 0", id_instr); end
        checks++; if (id_adel !== 1'b0) begin errors++; $display("FAIL reset_id_adel: got %b expected 0", id_adel); end
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        logic [31:0] pcs   [3];
        words[0] = 32'h2408_0005; words[1] = 32'h0109_5020; words[2] = 32'hAFBF_0010;
        pcs[0]   = 32'hBFC0_0000; pcs[1]   = 32'hBFC0_0004; pcs[2]   = 32'hBFC0_0008;
        inst_addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_data_ok = 1'b0;
            tick();
            checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL seq_wait_req[%0d]: got %b expected 0", i, inst_req); end
            inst_data_ok = 1'b1;
            inst_rdata   = words[i];
            tick();
            inst_data_ok = 1'b0;
            checks++; if (id_valid !== 1'b1 || id_pc !== pcs[i] || id_instr !== words[i] || id_adel !== 1'b0) begin
                errors++; $display("FAIL seq_id[%0d]: got v=%b pc=%h instr=%h adel=%b expected v=1 pc=%h instr=%h adel=0", i, id_valid, id_pc, id_instr, id_adel, pcs[i], words[i]);
            end
            checks++; if (inst_req !== 1'b1 || inst_addr !== pcs[i] + 32'd4) begin
                errors++; $display("FAIL seq_next_req[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, inst_req, inst_addr, pcs[i] + 32'd4);
            end
        end
    endtask

    task automatic test_skid();
        // IF/ID holds the BFC00008 word; decode stalls.
        stall        = 1'b1;
        inst_addr_ok = 1'b1;
        tick();                         // REQ -> WAIT for BFC0000C
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h2402_0001;
        tick();                         // WAIT -> SKID
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC0_0008 || id_instr !== 32'hAFBF_0010) begin
            errors++; $display("FAIL skid_id_held: got v=%b pc=%h instr=%h expected v=1 pc=bfc00008 instr=afbf0010", id_valid, id_pc, id_instr);
        end
        tick();
        checks++; if (inst_req !== 1'b0 || id_instr !== 32'hAFBF_0010) begin
            errors++; $display("FAIL skid_hold: got req=%b instr=%h expected req=0 instr=afbf0010", inst_req, id_instr);
        end
        stall = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC0_000C || id_instr !== 32'h2402_0001) begin
            errors++; $display("FAIL skid_release: got v=%b pc=%h instr=%h expected v=1 pc=bfc0000c instr=24020001", id_valid, id_pc, id_instr);
        end
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0010) begin
            errors++; $display("FAIL skid_next_req: got req=%b addr=%h expected req=1 addr=bfc00010", inst_req, inst_addr);
        end
        tick();                         // entry consumed, pc unchanged while addr_ok held
    endtask

    task automatic test_redirect_wait();
        // After the previous tick the DUT accepted BFC00010 and sits in WAIT.
        inst_addr_ok   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0180;
        tick();                         // WAIT -> DISCARD
        redirect_valid = 1'b0;
        checks++; if (id_valid !== 1'b0 || inst_req !== 1'b0 || inst_addr !== 32'h8000_0180) begin
            errors++; $display("FAIL redir_wait: got v=%b req=%b addr=%h expected v=0 req=0 addr=80000180", id_valid, inst_req, inst_addr);
        end
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEAD_BEEF;
        tick();                         // stale data dropped
        inst_data_ok = 1'b0;
        checks++; if (id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h8000_0180) begin
            errors++; $display("FAIL redir_drop: got v=%b req=%b addr=%h expected v=0 req=1 addr=80000180", id_valid, inst_req, inst_addr);
        end
        tick();                         // accepted
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h1111_1111;
        tick();
        inst_data_ok = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8000_0180 || id_instr !== 32'h1111_1111) begin
            errors++; $display("FAIL redir_fetch: got v=%b pc=%h instr=%h expected v=1 pc=80000180 instr=11111111", id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_redirect_data_same();
        inst_addr_ok = 1'b1;
        tick();                         // REQ -> WAIT for 80000184
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        inst_data_ok   = 1'b1;
        inst_rdata     = 32'hCAFE_F00D;
        tick();
        redirect_valid = 1'b0;
        inst_data_ok   = 1'b0;
        checks++; if (id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h8000_0200) begin
            errors++; $display("FAIL redir_same: got v=%b req=%b addr=%h expected v=0 req=1 addr=80000200", id_valid, inst_req, inst_addr);
        end
    endtask

    task automatic test_adel();
        inst_addr_ok   = 1'b0;
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0002;
        tick();
        redirect_valid = 1'b0;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL adel_no_req: got %b expected 0", inst_req); end
        inst_addr_ok = 1'b1;
        tick();
        checks++; if (id_valid !== 1'b1 || id_adel !== 1'b1 || id_pc !== 32'h8000_0002 || id_instr !== 32'h0) begin
            errors++; $display("FAIL adel_entry: got v=%b adel=%b pc=%h instr=%h expected v=1 adel=1 pc=80000002 instr=0", id_valid, id_adel, id_pc, id_instr);
        end
        tick();
        tick();
        checks++; if (inst_req !== 1'b0 || id_valid !== 1'b1 || id_adel !== 1'b1 || inst_addr !== 32'h8000_0002) begin
            errors++; $display("FAIL adel_hold: got req=%b v=%b adel=%b addr=%h expected req=0 v=1 adel=1 addr=80000002", inst_req, id_valid, id_adel, inst_addr);
        end
        inst_addr_ok   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC0_0380;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0380 || id_valid !== 1'b0) begin
            errors++; $display("FAIL adel_resume: got req=%b addr=%h v=%b expected req=1 addr=bfc00380 v=0", inst_req, inst_addr, id_valid);
        end
    endtask

    task automatic test_wrap();
        inst_addr_ok   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        inst_addr_ok   = 1'b1;
        tick();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hA5A5_A5A5;
        tick();
        inst_data_ok = 1'b0;
        checks++; if (id_pc !== 32'hFFFF_FFFC || id_instr !== 32'hA5A5_A5A5 || inst_req !== 1'b1 || inst_addr !== 32'h0) begin
            errors++; $display("FAIL wrap: got pc=%h instr=%h req=%b addr=%h expected pc=fffffffc instr=a5a5a5a5 req=1 addr=0", id_pc, id_instr, inst_req, inst_addr);
        end
    endtask

    task automatic test_reset_in_skid();
        stall        = 1'b1;            // id_valid=1 from the wrap fetch
        inst_addr_ok = 1'b1;
        tick();                         // REQ -> WAIT
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h7777_7777;
        tick();                         // WAIT -> SKID
        inst_data_ok = 1'b0;
        checks++; if (inst_req !== 1'b0 || id_valid !== 1'b1) begin
            errors++; $display("FAIL rst_skid_pre: got req=%b v=%b expected req=0 v=1", inst_req, id_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stall = 1'b0;
        checks++; if (id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0000 || id_pc !== 32'h0) begin
            errors++; $display("FAIL rst_skid: got v=%b req=%b addr=%h pc=%h expected v=0 req=1 addr=bfc00000 pc=0", id_valid, inst_req, inst_addr, id_pc);
        end
    endtask

    initial begin
        reset          = 1'b0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;

        test_reset();
        test_sequential();
        test_skid();
        test_redirect_wait();
        test_redirect_data_same();
        test_adel();
        test_wrap();
        test_reset_in_skid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
